hsv_to_rgb: RTL and testbench
=============================

Name: hsv_to_rgb

Overview:
- Inverse of the skin pipeline's RGB→HSV hue path: takes absolute hue plus saturation/value and rebuilds R,G,B.
- Hue is split back into a 60° sector index and an in-sector offset, then the channels are rebuilt.
- Used to render detected skin-hue classes back to RGB for the overlay/debug video path.
- Multi-cycle FSM with valid/ready on both sides, gated by ce.

Parameters:
HW, 10, hue input width; hue units are degrees, nominally 0..359
CW, 8, channel width for s, v, r, g, b; full scale M = 2^CW-1 (255)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-high
ce  in  1  clock enable; low = all state, counters and outputs frozen
in_valid  in  1  h/s/v present
in_ready  out  1  high only in IDLE (combinational from state)
h  in  HW  hue, degrees
s  in  CW  saturation, 0..M
v  in  CW  value, 0..M
out_valid  out  1  r/g/b valid, held until accepted
out_ready  in  1  downstream accepts result
r  out  CW  red
g  out  CW  green
b  out  CW  blue

Behaviour:
- Reset (rst high at posedge, ce ignored): state←IDLE; r,g,b←0; out_valid←0; in_ready reads 1 from the first cycle after reset. Reset during any state aborts the operation and discards its result.
- All non-reset updates require ce=1. With ce=0, the block holds everything, including handshake state.
- IDLE: on in_valid & in_ready, latch h, s, v. Set rem←h (after the optional-feature adjustment), sector←0. Go to SECT.
- SECT: one step per cycle.
  - If rem≥60: rem←rem-60 and sector←sector+1. Whether sector wraps 5→0 is set by the optional feature.
  - Else: f←rem (0..59), then go to FRAC.
  - Occupies floor(h'/60)+1 cycles, where h' is the adjusted hue.
- FRAC:
  - a←floor(s·f/60)
  - b←floor(s·(60-f)/60)
  - Exact floor results are required; any method is allowed within the one cycle.
- SCALE:
  - p←floor(v·(M-s)/M)
  - q←floor(v·(M-a)/M)
  - t←floor(v·(M-b)/M)
  - Exact floor is required (s=0 must give p=q=t=v).
  - Register (r,g,b) by sector: 0:(v,t,p) 1:(q,v,p) 2:(p,v,t) 3:(p,q,v) 4:(t,p,v) 5:(v,p,q).
  - Set out_valid←1 and go to DONE.
- DONE:
  - r, g, b and out_valid are held stable.
  - On out_ready: out_valid←0 and go to IDLE. in_ready rises the next cycle; there is no same-cycle pass-through.
- Latency (ce always 1): out_valid rises floor(h'/60)+3 posedges after the accepting posedge. Throughput is one result per latency+2 cycles at minimum.
- Inputs are not sampled outside the IDLE accept. Changing h/s/v mid-operation has no effect.
- s>M and v>M cannot occur (full width). Intermediates are sized for M·M without overflow.

Optional Feature:
- HSV2RGB_WRAP_EN defined:
  - h'=h. The sector counter wraps 5→0, so any h up to 2^HW-1 maps to h mod 360.
  - Latency stays floor(h/60)+3.
- Not defined:
  - At accept, h≥360 is saturated to h'=359.
  - The sector counter never exceeds 5.
  - Maximum latency is 8.

Test Plan:
- h=0,s=255,v=255 → (255,0,0), out_valid 3 cycles after accept; in_ready low until out_ready handshake.
- h=120,s=255,v=200 → (0,200,0), latency 5.
- h=90,s=128,v=200 → sector1, f=30, a=64 → (149,200,99), latency 4.
- h=300,s=0,v=77 → (77,77,77), latency 8.
- h=400,s=255,v=255:
  - WRAP_EN: (255,170,0), latency 9.
  - Without: clamped to 359 → (255,0,5), latency 8.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles: r/g/b and out_valid stay stable, and a second in_valid is not accepted.
  - Pulse ce=0 for 4 cycles mid-SECT: latency grows by exactly 4.
  - Assert rst mid-SECT: next cycle r=g=b=0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/hsv_to_rgb.sv
// hsv_to_rgb: rebuilds R,G,B from an absolute hue (degrees) plus
// saturation/value. Used to paint classified skin hues back onto the
// overlay/debug video path.
//
// Operation: the hue is reduced to a 60-degree sector index by repeated
// subtraction, one step per cycle. The in-sector offset f then gives the
// ramp terms a = s*f/60 and b = s*(60-f)/60. Finally p/q/t are scaled by v
// and routed to r/g/b according to the sector. All divisions are exact floors.
//
// Ports:
//   clk        system clock, posedge
//   rst        synchronous reset, active-high (overrides ce)
//   ce         clock enable; low freezes every register
//   in_valid   h/s/v present
//   in_ready   high only while idle
//   h          hue in degrees (HW bits)
//   s, v       saturation / value, 0..2^CW-1
//   out_valid  r/g/b valid, held until out_ready
//   out_ready  downstream accepts result
//   r, g, b    output channels
//
// Build option HSV2RGB_WRAP_EN:
//   defined   - any hue is accepted and reduced modulo 360 (sector wraps 5->0)
//   undefined - hues >= 360 are clamped to 359 when accepted
module hsv_to_rgb #(
  parameter int HW = 10,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [HW-1:0] h,
  input  logic [CW-1:0] s,
  input  logic [CW-1:0] v,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b
);

  localparam logic [CW-1:0]   M_FULL   = '1;
  localparam logic [HW-1:0]   DEG60    = HW'(60);
  localparam logic [CW+5:0]   SIXTY_W  = (CW+6)'(60);
  localparam logic [2*CW-1:0] M_WIDE   = {{CW{1'b0}}, M_FULL};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SECT,
    S_FRAC,
    S_SCALE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] rem_q, rem_d;
  logic [2:0]    sector_q, sector_d;
  logic [5:0]    f_q, f_d;
  logic [CW-1:0] s_q, s_d;
  logic [CW-1:0] v_q, v_d;
  logic [CW-1:0] ca_q, ca_d;
  logic [CW-1:0] cb_q, cb_d;
  logic [CW-1:0] r_q, r_d;
  logic [CW-1:0] g_q, g_d;
  logic [CW-1:0] b_q, b_d;
  logic          out_valid_q, out_valid_d;

  logic [HW-1:0]   h_adj;
  logic [CW+5:0]   prod_a, prod_b;
  logic [2*CW-1:0] prod_p, prod_q, prod_t;
  logic [CW-1:0]   p_val, q_val, t_val;

  // Hue as it enters the sector reduction.
  always_comb begin
`ifdef HSV2RGB_WRAP_EN
    h_adj = h;
`else
    h_adj = (h >= HW'(360)) ? HW'(359) : h;
`endif
  end

  // Ramp terms and v-scaled channel levels. Products stay below M*M and
  // 60*M, so the widened operands cannot overflow.
  always_comb begin
    prod_a = {6'd0, s_q} * {{CW{1'b0}}, f_q};
    prod_b = {6'd0, s_q} * {{CW{1'b0}}, 6'd60 - f_q};
    prod_p = {{CW{1'b0}}, v_q} * {{CW{1'b0}}, M_FULL - s_q};
    prod_q = {{CW{1'b0}}, v_q} * {{CW{1'b0}}, M_FULL - ca_q};
    prod_t = {{CW{1'b0}}, v_q} * {{CW{1'b0}}, M_FULL - cb_q};
    p_val  = CW'(prod_p / M_WIDE);
    q_val  = CW'(prod_q / M_WIDE);
    t_val  = CW'(prod_t / M_WIDE);
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    sector_d    = sector_q;
    f_d         = f_q;
    s_d         = s_q;
    v_d         = v_q;
    ca_d        = ca_q;
    cb_d        = cb_q;
    r_d         = r_q;
    g_d         = g_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          rem_d    = h_adj;
          sector_d = 3'd0;
          s_d      = s;
          v_d      = v;
          state_d  = S_SECT;
        end
      end
      S_SECT: begin
        if (rem_q >= DEG60) begin
          rem_d = rem_q - DEG60;
`ifdef HSV2RGB_WRAP_EN
          sector_d = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
`else
          // Clamped hue never reaches a seventh sector; hold at 5 regardless.
          sector_d = (sector_q == 3'd5) ? 3'd5 : sector_q + 3'd1;
`endif
        end else begin
          f_d     = rem_q[5:0];
          state_d = S_FRAC;
        end
      end
      S_FRAC: begin
        ca_d    = CW'(prod_a / SIXTY_W);
        cb_d    = CW'(prod_b / SIXTY_W);
        state_d = S_SCALE;
      end
      S_SCALE: begin
        case (sector_q)
          3'd0:    begin r_d = v_q;   g_d = t_val; b_d = p_val; end
          3'd1:    begin r_d = q_val; g_d = v_q;   b_d = p_val; end
          3'd2:    begin r_d = p_val; g_d = v_q;   b_d = t_val; end
          3'd3:    begin r_d = p_val; g_d = q_val; b_d = v_q;   end
          3'd4:    begin r_d = t_val; g_d = p_val; b_d = v_q;   end
          default: begin r_d = v_q;   g_d = p_val; b_d = q_val; end
        endcase
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      sector_q    <= '0;
      f_q         <= '0;
      s_q         <= '0;
      v_q         <= '0;
      ca_q        <= '0;
      cb_q        <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
    end else if (ce) begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      sector_q    <= sector_d;
      f_q         <= f_d;
      s_q         <= s_d;
      v_q         <= v_d;
      ca_q        <= ca_d;
      cb_q        <= cb_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign g         = g_q;
  assign b         = b_q;

endmodule

// File: tb/tb_hsv_to_rgb.sv
// Self-checking bench for hsv_to_rgb: expected results are queued when a
// vector is driven and compared when the output handshake completes.
module tb_hsv_to_rgb;
  localparam int HW = 10;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, ce, in_valid, in_ready, out_valid, out_ready;
  logic [HW-1:0] h;
  logic [CW-1:0] s, v, r, g, b;

  always #5 clk = ~clk;

  hsv_to_rgb #(.HW(HW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .h(h), .s(s), .v(v),
    .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .g(g), .b(b)
  );

  typedef struct {
    int r;
    int g;
    int b;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   acc_cnt  = 0;
  int   done_cnt = 0;
  int   lat_meas = 0;
  bit   ov_seen  = 1'b0;

  task automatic check(input string tag, input int got, input int expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Reference: direct sector/offset split instead of iterative subtraction.
  function automatic exp_t model(input int hh, input int ss, input int vv);
    int hp, sec, f, a, bq, p, q, t;
    exp_t e;
`ifdef HSV2RGB_WRAP_EN
    hp    = hh % 360;
    e.lat = hh / 60 + 3;
`else
    hp    = (hh >= 360) ? 359 : hh;
    e.lat = hp / 60 + 3;
`endif
    sec = hp / 60;
    f   = hp % 60;
    a   = (ss * f) / 60;
    bq  = (ss * (60 - f)) / 60;
    p   = (vv * (255 - ss)) / 255;
    q   = (vv * (255 - a)) / 255;
    t   = (vv * (255 - bq)) / 255;
    case (sec)
      0:       begin e.r = vv; e.g = t;  e.b = p;  end
      1:       begin e.r = q;  e.g = vv; e.b = p;  end
      2:       begin e.r = p;  e.g = vv; e.b = t;  end
      3:       begin e.r = p;  e.g = q;  e.b = vv; end
      4:       begin e.r = t;  e.g = p;  e.b = vv; end
      default: begin e.r = vv; e.g = p;  e.b = q;  end
    endcase
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: observes handshakes at negedge, ahead of the posedge that commits them.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      ov_seen = 1'b0;
    end else begin
      if (in_valid && in_ready && ce) begin
        acc_cyc = cyc + 1;
        acc_cnt++;
      end
      if (out_valid && !ov_seen) begin
        ov_seen  = 1'b1;
        lat_meas = cyc - acc_cyc;
        check("in_ready_busy", int'(in_ready), 0);
      end
      if (out_valid && out_ready && ce) begin
        check("no_passthru", int'(in_ready), 0);
        if (exp_q.size() == 0) begin
          check("sb_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("r", int'(r), e.r);
          check("g", int'(g), e.g);
          check("b", int'(b), e.b);
          check("latency", lat_meas, e.lat);
          $display("txn %0d: rgb=(%0d,%0d,%0d) exp=(%0d,%0d,%0d) lat=%0d exp_lat=%0d",
                   done_cnt, r, g, b, e.r, e.g, e.b, lat_meas, e.lat);
        end
        ov_seen = 1'b0;
        done_cnt++;
      end
    end
  end

  task automatic run_vec(input int hh, input int ss, input int vv,
                         input int er, input int eg, input int eb, input int el,
                         input int stall);
    exp_t e;
    int a0, d0;
    e.r = er; e.g = eg; e.b = eb; e.lat = el;
    exp_q.push_back(e);
    a0 = acc_cnt;
    d0 = done_cnt;
    h = hh[HW-1:0];
    s = ss[CW-1:0];
    v = vv[CW-1:0];
    in_valid = 1'b1;
    for (int i = 0; i < 40 && acc_cnt == a0; i++) begin
      @(posedge clk); #1;
    end
    if (acc_cnt == a0) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
    if (stall > 0) begin
      repeat (2) @(posedge clk);
      #1 ce = 1'b0;
      repeat (stall) @(posedge clk);
      #1 ce = 1'b1;
    end
    for (int i = 0; i < 60 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
    end
    if (done_cnt == d0) check("done_timeout", 0, 1);
    else check("in_ready_after", int'(in_ready), 1);
  endtask

  initial begin
    exp_t e;
    int a0, d0, hh, ss, vv;
    rst = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    h = '0; s = '0; v = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_r", int'(r), 0);
    check("rst_g", int'(g), 0);
    check("rst_b", int'(b), 0);
    @(posedge clk); #1;

    run_vec(0,   255, 255, 255, 0,   0,   3, 0);
    run_vec(120, 255, 200, 0,   200, 0,   5, 0);
    run_vec(90,  128, 200, 149, 200, 99,  4, 0);
    run_vec(300, 0,   77,  77,  77,  77,  8, 0);
`ifdef HSV2RGB_WRAP_EN
    run_vec(400, 255, 255, 255, 170, 0,   9, 0);
`else
    run_vec(400, 255, 255, 255, 0,   5,   8, 0);
`endif
    // ce held low for 4 cycles during sector reduction
    run_vec(300, 0,   77,  77,  77,  77,  12, 4);

    // Backpressure: result held, no second accept while busy
    out_ready = 1'b0;
    e.r = 149; e.g = 200; e.b = 99; e.lat = 4;
    exp_q.push_back(e);
    d0 = done_cnt;
    h = 10'd90; s = 8'd128; v = 8'd200; in_valid = 1'b1;
    a0 = acc_cnt;
    for (int i = 0; i < 40 && acc_cnt == a0; i++) begin
      @(posedge clk); #1;
    end
    if (acc_cnt == a0) check("bp_accept_timeout", 0, 1);
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("bp_out_valid_rise", int'(out_valid), 1);
    h = 10'd200; s = 8'd50; v = 8'd50; in_valid = 1'b1;
    a0 = acc_cnt;
    repeat (10) begin
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_r", int'(r), 149);
      check("bp_g", int'(g), 200);
      check("bp_b", int'(b), 99);
      check("bp_in_ready", int'(in_ready), 0);
    end
    check("bp_no_accept", acc_cnt, a0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
    end
    if (done_cnt == d0) check("bp_done_timeout", 0, 1);

    // Random vectors across the full hue range
    for (int k = 0; k < 16; k++) begin
      hh = int'($urandom_range(0, 1023));
      ss = int'($urandom_range(0, 255));
      vv = int'($urandom_range(0, 255));
      e = model(hh, ss, vv);
      run_vec(hh, ss, vv, e.r, e.g, e.b, e.lat, 0);
    end

    // Reset mid-operation: leave nonzero outputs first, then abort
    run_vec(0, 255, 255, 255, 0, 0, 3, 0);
    h = 10'd300; s = 8'd255; v = 8'd255; in_valid = 1'b1;
    a0 = acc_cnt;
    for (int i = 0; i < 40 && acc_cnt == a0; i++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_r", int'(r), 0);
    check("abort_g", int'(g), 0);
    check("abort_b", int'(b), 0);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_in_ready", int'(in_ready), 1);
    repeat (12) @(negedge clk);
    check("abort_discarded", int'(out_valid), 0);
    @(posedge clk); #1;

    // Recovery after abort
    run_vec(60, 255, 255, 255, 255, 0, 4, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
